icebus_status_decoder: RTL

ICEBUS_STATUS_DECODER -- requirements
Module: icebus_status_decoder

---
 rtl/icebus_status_decoder.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/icebus_status_decoder.sv
// ---------------------------------------------------------------------------
// icebus_status_decoder
//
// Decodes ICEbus motor status frames arriving one byte at a time from a UART
// receiver. A frame is 31 bytes:
//   0xA5 (SOF), motor ID, 28 payload bytes, checksum byte.
// The payload carries seven signed 32-bit fields, each sent MSB first, in
// this order: encoder0_position, encoder1_position, encoder0_velocity,
// encoder1_velocity, current_phase1, current_phase2, current_phase3.
//
// Optional feature macro: STATUS_CHECKSUM_EN
//   defined   - the 8-bit sum of ID, payload and checksum byte must be 0x00,
//               otherwise checksum_error pulses and the frame is dropped.
//   undefined - the checksum byte is consumed but ignored, every complete
//               frame is good, and checksum_error is tied low.
//
// Parameters
//   NUMBER_OF_MOTORS    - valid motor IDs are 0 .. NUMBER_OF_MOTORS-1
//   BYTE_TIMEOUT_CYCLES - longest allowed gap (clk cycles) between the bytes
//                         of one frame
//
// Ports
//   clk               in   single clock, rising edge
//   reset             in   asynchronous, active-low reset
//   rx_data[7:0]      in   received byte
//   rx_valid          in   one-cycle strobe, rx_data consumed this cycle
//   frame_valid       out  one-cycle strobe, good frame committed to outputs
//   motor_id[7:0]     out  motor index of the last good frame
//   encoder*/current* out  signed 32-bit fields of the last good frame
//   checksum_error    out  one-cycle strobe, checksum mismatch
//   id_error          out  one-cycle strobe, motor ID out of range
//   timeout_error     out  one-cycle strobe, inter-byte gap too long
//   frame_count[15:0] out  number of good frames, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module icebus_status_decoder #(
    parameter int NUMBER_OF_MOTORS    = 6,
    parameter int BYTE_TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               frame_valid,
    output logic [7:0]         motor_id,
    output logic signed [31:0] encoder0_position,
    output logic signed [31:0] encoder1_position,
    output logic signed [31:0] encoder0_velocity,
    output logic signed [31:0] encoder1_velocity,
    output logic signed [31:0] current_phase1,
    output logic signed [31:0] current_phase2,
    output logic signed [31:0] current_phase3,
    output logic               checksum_error,
    output logic               id_error,
    output logic               timeout_error,
    output logic [15:0]        frame_count
);

    localparam int             GAP_W        = $clog2(BYTE_TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(BYTE_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     SOF          = 8'hA5;
    localparam logic [4:0]     LAST_PAYLOAD = 5'd27;
    localparam logic [8:0]     MOTOR_LIMIT  = 9'(NUMBER_OF_MOTORS);

    typedef enum logic [1:0] {
        IDLE,
        ID,
        PAYLOAD,
        CHECK
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [GAP_W-1:0]   gap_count;
    logic [4:0]         byte_count;
    logic [223:0]       staging;
    logic [7:0]         id_staged;

    logic               timeout_hit;
    logic               load_id;
    logic               shift_payload;
    logic               commit_good;
    logic               id_bad;

`ifdef STATUS_CHECKSUM_EN
    logic [7:0]         checksum_sum;
    logic [7:0]         check_total;
    logic               checksum_ok;
    logic               commit_bad;

    assign check_total = checksum_sum + rx_data;
    assign checksum_ok = (check_total == 8'h00);
`endif

    // The gap counter only runs while a frame is in flight. The expiry cycle
    // is the one in which the counter would reach the limit; a byte arriving
    // in that same cycle takes priority, so the timeout needs !rx_valid.
    assign timeout_hit = (state != IDLE) && !rx_valid && (gap_count == GAP_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the per-byte control strobes for the datapath.
    // A 0xA5 outside IDLE is ordinary data; there is no resynchronisation.
    always_comb begin
        next_state    = state;
        load_id       = 1'b0;
        shift_payload = 1'b0;
        commit_good   = 1'b0;
        id_bad        = 1'b0;
`ifdef STATUS_CHECKSUM_EN
        commit_bad    = 1'b0;
`endif
        if (timeout_hit) begin
            next_state = IDLE;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == SOF) begin
                        next_state = ID;
                    end
                end
                ID: begin
                    if ({1'b0, rx_data} < MOTOR_LIMIT) begin
                        load_id    = 1'b1;
                        next_state = PAYLOAD;
                    end else begin
                        id_bad     = 1'b1;
                        next_state = IDLE;
                    end
                end
                PAYLOAD: begin
                    shift_payload = 1'b1;
                    if (byte_count == LAST_PAYLOAD) begin
                        next_state = CHECK;
                    end
                end
                CHECK: begin
                    next_state = IDLE;
`ifdef STATUS_CHECKSUM_EN
                    if (checksum_ok) begin
                        commit_good = 1'b1;
                    end else begin
                        commit_bad  = 1'b1;
                    end
`else
                    commit_good = 1'b1;
`endif
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Inter-byte gap counter: cleared by every byte and whenever idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_count <= '0;
        end else if (state == IDLE || rx_valid || timeout_hit) begin
            gap_count <= '0;
        end else begin
            gap_count <= gap_count + GAP_W'(1);
        end
    end

    // Payload staging: bytes shift in from the bottom so that after 28 bytes
    // the first field sent sits in the top 32 bits. A timeout throws the
    // partial frame away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_count <= '0;
            staging    <= '0;
            id_staged  <= '0;
        end else if (timeout_hit) begin
            byte_count <= '0;
            staging    <= '0;
            id_staged  <= '0;
        end else if (load_id) begin
            byte_count <= '0;
            id_staged  <= rx_data;
        end else if (shift_payload) begin
            byte_count <= byte_count + 5'd1;
            staging    <= {staging[215:0], rx_data};
        end
    end

`ifdef STATUS_CHECKSUM_EN
    // Running 8-bit sum of the ID and payload bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_sum <= '0;
        end else if (timeout_hit) begin
            checksum_sum <= '0;
        end else if (load_id) begin
            checksum_sum <= rx_data;
        end else if (shift_payload) begin
            checksum_sum <= checksum_sum + rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_error <= 1'b0;
        end else begin
            checksum_error <= commit_bad;
        end
    end
`else
    assign checksum_error = 1'b0;
`endif

    // Error strobes, each high for exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_error      <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            id_error      <= id_bad;
            timeout_error <= timeout_hit;
        end
    end

    // Output commit. Registering on the checksum byte makes the new values
    // and frame_valid appear in the cycle after that byte, while the FSM is
    // already back in IDLE and able to take a back-to-back SOF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_valid       <= 1'b0;
            motor_id          <= '0;
            encoder0_position <= '0;
            encoder1_position <= '0;
            encoder0_velocity <= '0;
            encoder1_velocity <= '0;
            current_phase1    <= '0;
            current_phase2    <= '0;
            current_phase3    <= '0;
            frame_count       <= '0;
        end else begin
            frame_valid <= commit_good;
            if (commit_good) begin
                motor_id          <= id_staged;
                encoder0_position <= $signed(staging[223:192]);
                encoder1_position <= $signed(staging[191:160]);
                encoder0_velocity <= $signed(staging[159:128]);
                encoder1_velocity <= $signed(staging[127:96]);
                current_phase1    <= $signed(staging[95:64]);
                current_phase2    <= $signed(staging[63:32]);
                current_phase3    <= $signed(staging[31:0]);
                frame_count       <= frame_count + 16'd1;
            end
        end
    end

endmodule
